// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern phase driver.
// - state_t: FSM states of the phase driver.
// - Field offsets: index of each BUF_WIDTH-wide field inside a pattern word.
//   Word order is PDRIVE, NDRIVE, PSENSE, PDELAY, PTWEAK0..n, NSENSE, NDELAY, NTWEAK0..n.
package pattern_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEAD,
    DRIVE_P,
    DRIVE_N
  } state_t;

  localparam int unsigned F_PDRIVE = 0;
  localparam int unsigned F_NDRIVE = 1;
  localparam int unsigned F_PSENSE = 2;
  localparam int unsigned F_PDELAY = 3;

  function automatic int unsigned num_fields(input int unsigned num_tweak);
    return 2 + 2 * (2 + num_tweak);
  endfunction

  function automatic int unsigned f_ptweak(input int unsigned k);
    return 4 + k;
  endfunction

  function automatic int unsigned f_nsense(input int unsigned num_tweak);
    return 4 + num_tweak;
  endfunction

  function automatic int unsigned f_ndelay(input int unsigned num_tweak);
    return 5 + num_tweak;
  endfunction

  function automatic int unsigned f_ntweak(input int unsigned num_tweak, input int unsigned k);
    return 6 + num_tweak + k;
  endfunction

endpackage

// File: rtl/pattern_phase_driver_if.sv
// Pattern word handshake between the pattern buffers and the phase driver.
// - cfg_valid : pattern word offered (master -> slave)
// - cfg_data  : full pattern word, DATA_W bits (master -> slave)
// - cfg_ready : shadow slot empty (slave -> master)
interface pattern_phase_driver_if #(
  parameter int unsigned DATA_W = 176
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DATA_W-1:0] cfg_data;

  modport master (output cfg_valid, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/pattern_shadow_reg.sv
// Double-buffered pattern store.
// - accept : load data into the shadow slot (ignored while a word is pending)
// - commit : PWM edge; moves a pending shadow word into the active store
// - ready  : shadow slot empty
// - active : active store as seen at this posedge, including a commit
//            happening on the same edge
module pattern_shadow_reg #(
  parameter int unsigned DATA_W = 176
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept,
  input  logic              commit,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic [DATA_W-1:0] active
);
  logic [DATA_W-1:0] shadow;
  logic [DATA_W-1:0] active_q;
  logic              pending;
  logic              do_commit;

  assign ready     = !pending;
  assign do_commit = commit && pending;
  // Forwarding lets a zero-dead-time phase entry drive the word committed on the same edge.
  assign active    = do_commit ? shadow : active_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow   <= '0;
      active_q <= '0;
      pending  <= 1'b0;
    end else if (do_commit) begin
      active_q <= shadow;
      pending  <= 1'b0;
    end else if (accept && !pending) begin
      shadow  <= data;
      pending <= 1'b1;
    end
  end
endmodule

// File: rtl/pattern_phase_driver.sv
// Pattern phase driver: drives P or N pad fields of the active pattern word
// on the current PWM phase with dead time inserted after every PWM edge.
// - clk, rst_n    : clock, synchronous active-low reset
// - pwm           : phase request, 1 = P, 0 = N
// - en            : 0 forces IDLE with all outputs off
// - cfg           : pattern word handshake (slave side)
// - p_drive, n_drive, tweak_sense, tweak_delay, tweak_drive : registered pad outputs
// - buffer_select : saturating cycle counter since the last PWM edge
// - phase_active  : 1 while driving P or N
module pattern_phase_driver
  import pattern_pkg::*;
#(
  parameter int unsigned BUF_WIDTH   = 8,
  parameter int unsigned NUM_TWEAK   = 8,
  parameter int unsigned NUM_SEL     = 8,
  parameter int unsigned DEAD_CYCLES = 2,
  parameter bit          GATE_SENSE  = 1'b0,
  parameter logic [BUF_WIDTH-1:0] P_OFF = '1,
  parameter logic [BUF_WIDTH-1:0] N_OFF = '0,
  localparam int unsigned NF    = num_fields(NUM_TWEAK),
  localparam int unsigned SEL_W = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           pwm,
  input  logic                           en,
  pattern_phase_driver_if.slave          cfg,
  output logic [BUF_WIDTH-1:0]           p_drive,
  output logic [BUF_WIDTH-1:0]           n_drive,
  output logic [BUF_WIDTH-1:0]           tweak_sense,
  output logic [BUF_WIDTH-1:0]           tweak_delay,
  output logic [NUM_TWEAK*BUF_WIDTH-1:0] tweak_drive,
  output logic [SEL_W-1:0]               buffer_select,
  output logic                           phase_active
);
  localparam int unsigned DCNT_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LOAD = (DEAD_CYCLES > 0) ? DCNT_W'(DEAD_CYCLES - 1) : '0;
  localparam logic [SEL_W-1:0]  SEL_MAX   = SEL_W'(NUM_SEL - 1);

  logic                           pwm_q;
  logic                           pwm_edge;
  state_t                         state, state_nxt;
  logic [DCNT_W-1:0]              dcnt, dcnt_nxt;
  logic [NF*BUF_WIDTH-1:0]        active;
  logic [BUF_WIDTH-1:0]           p_sense, p_delay, n_sense, n_delay;
  logic [NUM_TWEAK*BUF_WIDTH-1:0] p_tweak, n_tweak;

  assign pwm_edge = pwm ^ pwm_q;

  pattern_shadow_reg #(
    .DATA_W (NF * BUF_WIDTH)
  ) u_shadow (
    .clk    (clk),
    .rst_n  (rst_n),
    .accept (cfg.cfg_valid && cfg.cfg_ready),
    .commit (pwm_edge),
    .data   (cfg.cfg_data),
    .ready  (cfg.cfg_ready),
    .active (active)
  );

  // Per-phase field extraction; optional masking keeps only tweak bits whose
  // sense bit matches the phase level (1 for P, 0 for N).
  always_comb begin
    p_sense = active[F_PSENSE*BUF_WIDTH +: BUF_WIDTH];
    p_delay = active[F_PDELAY*BUF_WIDTH +: BUF_WIDTH];
    n_sense = active[f_nsense(NUM_TWEAK)*BUF_WIDTH +: BUF_WIDTH];
    n_delay = active[f_ndelay(NUM_TWEAK)*BUF_WIDTH +: BUF_WIDTH];
    p_tweak = '0;
    n_tweak = '0;
    for (int unsigned k = 0; k < NUM_TWEAK; k++) begin
      p_tweak[k*BUF_WIDTH +: BUF_WIDTH] = active[f_ptweak(k)*BUF_WIDTH +: BUF_WIDTH];
      n_tweak[k*BUF_WIDTH +: BUF_WIDTH] = active[f_ntweak(NUM_TWEAK, k)*BUF_WIDTH +: BUF_WIDTH];
      if (GATE_SENSE) begin
        p_tweak[k*BUF_WIDTH +: BUF_WIDTH] &= p_sense;
        n_tweak[k*BUF_WIDTH +: BUF_WIDTH] &= ~n_sense;
      end
    end
  end

  // Next-state decision; the output registers below follow state_nxt so the
  // state change and the pad values update on the same posedge.
  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE, DRIVE_P, DRIVE_N: begin
          if (pwm_edge) begin
            if (DEAD_CYCLES == 0) begin
              state_nxt = pwm ? DRIVE_P : DRIVE_N;
            end else begin
              state_nxt = DEAD;
              dcnt_nxt  = DCNT_LOAD;
            end
          end
        end
        DEAD: begin
          if (pwm_edge) begin
            dcnt_nxt = DCNT_LOAD;
          end else if (dcnt == '0) begin
            state_nxt = pwm_q ? DRIVE_P : DRIVE_N;
          end else begin
            dcnt_nxt = dcnt - 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      dcnt          <= '0;
      pwm_q         <= 1'b0;
      buffer_select <= '0;
      p_drive       <= P_OFF;
      n_drive       <= N_OFF;
      tweak_sense   <= '0;
      tweak_delay   <= '0;
      tweak_drive   <= '0;
      phase_active  <= 1'b0;
    end else begin
      pwm_q <= pwm;
      state <= state_nxt;
      dcnt  <= dcnt_nxt;

      if (pwm_edge) begin
        buffer_select <= '0;
      end else if (buffer_select != SEL_MAX) begin
        buffer_select <= buffer_select + 1'b1;
      end

      unique case (state_nxt)
        DRIVE_P: begin
          p_drive      <= active[F_PDRIVE*BUF_WIDTH +: BUF_WIDTH];
          n_drive      <= N_OFF;
          tweak_sense  <= p_sense;
          tweak_delay  <= p_delay;
          tweak_drive  <= p_tweak;
          phase_active <= 1'b1;
        end
        DRIVE_N: begin
          p_drive      <= P_OFF;
          n_drive      <= active[F_NDRIVE*BUF_WIDTH +: BUF_WIDTH];
          tweak_sense  <= n_sense;
          tweak_delay  <= n_delay;
          tweak_drive  <= n_tweak;
          phase_active <= 1'b1;
        end
        default: begin
          p_drive      <= P_OFF;
          n_drive      <= N_OFF;
          tweak_sense  <= '0;
          tweak_delay  <= '0;
          tweak_drive  <= '0;
          phase_active <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pattern_phase_driver.sv
// Bench for pattern_phase_driver: two instances share one stimulus stream.
// - dut0: defaults (DEAD_CYCLES=2, GATE_SENSE=0, NUM_SEL=8)
// - dut1: DEAD_CYCLES=0, GATE_SENSE=1, NUM_SEL=4
// A behavioural model tracks "cycles since the last edge" per instance and
// the shadow/active word store, and every cycle's outputs are compared.
module tb_pattern_phase_driver;
  localparam int unsigned W  = 8;
  localparam int unsigned NT = 8;
  localparam int unsigned NF = 2 + 2 * (2 + NT);
  localparam int unsigned DW = NF * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pwm = 1'b0;
  logic          en = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [DW-1:0] cfg_data = '0;

  always #5 clk = ~clk;

  pattern_phase_driver_if #(.DATA_W(DW)) if0 ();
  pattern_phase_driver_if #(.DATA_W(DW)) if1 ();
  assign if0.cfg_valid = cfg_valid;
  assign if0.cfg_data  = cfg_data;
  assign if1.cfg_valid = cfg_valid;
  assign if1.cfg_data  = cfg_data;

  logic [W-1:0]    p0, n0, s0, d0, p1, n1, s1, d1;
  logic [NT*W-1:0] t0, t1;
  logic [2:0]      b0;
  logic [1:0]      b1;
  logic            a0, a1;

  pattern_phase_driver dut0 (
    .clk (clk), .rst_n (rst_n), .pwm (pwm), .en (en), .cfg (if0),
    .p_drive (p0), .n_drive (n0), .tweak_sense (s0), .tweak_delay (d0),
    .tweak_drive (t0), .buffer_select (b0), .phase_active (a0)
  );

  pattern_phase_driver #(
    .DEAD_CYCLES (0),
    .GATE_SENSE  (1'b1),
    .NUM_SEL     (4)
  ) dut1 (
    .clk (clk), .rst_n (rst_n), .pwm (pwm), .en (en), .cfg (if1),
    .p_drive (p1), .n_drive (n1), .tweak_sense (s1), .tweak_delay (d1),
    .tweak_drive (t1), .buffer_select (b1), .phase_active (a1)
  );

  // ---------------- behavioural model ----------------
  int unsigned     m_dead[2] = '{2, 0};
  bit              m_gate[2] = '{1'b0, 1'b1};
  int unsigned     m_nsel[2] = '{8, 4};
  bit              m_pwmq, m_edge, m_pending;
  logic [DW-1:0]   m_shadow, m_active;
  int unsigned     m_sel[2], m_off[2];
  bit              m_armed[2];
  logic [W-1:0]    e_p[2], e_n[2], e_s[2], e_d[2], tw;
  logic [NT*W-1:0] e_t[2];
  bit              e_act[2];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pwmq = 1'b0; m_pending = 1'b0; m_shadow = '0; m_active = '0;
      for (int i = 0; i < 2; i++) begin
        m_sel[i] = 0; m_off[i] = 0; m_armed[i] = 1'b0;
        e_p[i] = 8'hFF; e_n[i] = 8'h00; e_s[i] = '0; e_d[i] = '0; e_t[i] = '0; e_act[i] = 1'b0;
      end
    end else begin
      m_edge = (pwm != m_pwmq);
      if (m_edge && m_pending) begin
        m_active = m_shadow; m_pending = 1'b0;
      end else if (cfg_valid && !m_pending) begin
        m_shadow = cfg_data; m_pending = 1'b1;
      end
      m_pwmq = pwm;
      for (int i = 0; i < 2; i++) begin
        if (m_edge) m_sel[i] = 0;
        else if (m_sel[i] < m_nsel[i] - 1) m_sel[i]++;
        if (!en) m_armed[i] = 1'b0;
        else if (m_edge) begin m_armed[i] = 1'b1; m_off[i] = m_dead[i]; end
        else if (m_armed[i] && m_off[i] > 0) m_off[i]--;
        e_p[i] = 8'hFF; e_n[i] = 8'h00; e_s[i] = '0; e_d[i] = '0; e_t[i] = '0; e_act[i] = 1'b0;
        if (m_armed[i] && m_off[i] == 0) begin
          e_act[i] = 1'b1;
          if (pwm) begin
            e_p[i] = m_active[0 +: W];
            e_s[i] = m_active[2*W +: W];
            e_d[i] = m_active[3*W +: W];
            for (int k = 0; k < NT; k++) begin
              tw = m_active[(4+k)*W +: W];
              if (m_gate[i]) tw = tw & e_s[i];
              e_t[i][k*W +: W] = tw;
            end
          end else begin
            e_n[i] = m_active[1*W +: W];
            e_s[i] = m_active[(4+NT)*W +: W];
            e_d[i] = m_active[(5+NT)*W +: W];
            for (int k = 0; k < NT; k++) begin
              tw = m_active[(6+NT+k)*W +: W];
              if (m_gate[i]) tw = tw & ~e_s[i];
              e_t[i][k*W +: W] = tw;
            end
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("p_drive0", 64'(p0), 64'(e_p[0]));
    chk("n_drive0", 64'(n0), 64'(e_n[0]));
    chk("sense0", 64'(s0), 64'(e_s[0]));
    chk("delay0", 64'(d0), 64'(e_d[0]));
    chk("tweak0", t0, e_t[0]);
    chk("bsel0", 64'(b0), 64'(m_sel[0]));
    chk("active0", 64'(a0), 64'(e_act[0]));
    chk("ready0", 64'(if0.cfg_ready), 64'(!m_pending));
    chk("p_drive1", 64'(p1), 64'(e_p[1]));
    chk("n_drive1", 64'(n1), 64'(e_n[1]));
    chk("sense1", 64'(s1), 64'(e_s[1]));
    chk("delay1", 64'(d1), 64'(e_d[1]));
    chk("tweak1", t1, e_t[1]);
    chk("bsel1", 64'(b1), 64'(m_sel[1]));
    chk("active1", 64'(a1), 64'(e_act[1]));
    chk("ready1", 64'(if1.cfg_ready), 64'(!m_pending));
  endtask

  // Fields default to seed + 29*f; the named fields are then overridden.
  function automatic logic [DW-1:0] mkword(input logic [7:0] seed, input logic [7:0] pd,
                                           input logic [7:0] nd, input logic [7:0] ps,
                                           input logic [7:0] pt0);
    logic [DW-1:0] w;
    for (int f = 0; f < NF; f++) w[f*W +: W] = seed + 8'(f * 29);
    w[0 +: W]   = pd;
    w[W +: W]   = nd;
    w[2*W +: W] = ps;
    w[4*W +: W] = pt0;
    return w;
  endfunction

  initial begin
    // Reset
    tick();
    chk("rst_p", 64'(p0), 64'h0FF);
    chk("rst_n", 64'(n0), 64'h000);
    chk("rst_ready", 64'(if0.cfg_ready), 64'h1);
    chk("rst_bsel", 64'(b0), 64'h0);
    chk("rst_active", 64'(a0), 64'h0);
    tick();
    rst_n = 1'b1;

    // Load word A while idle
    cfg_valid = 1'b1;
    cfg_data  = mkword(8'h10, 8'hA5, 8'h5A, 8'h0F, 8'hFF);
    tick();
    chk("A_pending_ready", 64'(if0.cfg_ready), 64'h0);
    cfg_valid = 1'b0;
    en = 1'b1;
    tick();

    // pwm 0->1: two dead cycles on dut0, immediate gated drive on dut1
    pwm = 1'b1;
    tick();
    chk("dead1_p", 64'(p0), 64'h0FF);
    chk("dead1_n", 64'(n0), 64'h000);
    chk("dead1_act", 64'(a0), 64'h0);
    chk("commit_ready", 64'(if0.cfg_ready), 64'h1);
    chk("nodead_p", 64'(p1), 64'h0A5);
    chk("gate_tweak0", 64'(t1[7:0]), 64'h00F);
    tick();
    chk("dead2_p", 64'(p0), 64'h0FF);
    chk("dead2_n", 64'(n0), 64'h000);
    tick();
    chk("drive_p", 64'(p0), 64'h0A5);
    chk("drive_act", 64'(a0), 64'h1);
    chk("drive_tweak0", 64'(t0[7:0]), 64'h0FF);

    // buffer_select saturation, restart on edge
    for (int i = 0; i < 12; i++) tick();
    chk("bsel_sat0", 64'(b0), 64'h7);
    chk("bsel_sat1", 64'(b1), 64'h3);
    pwm = 1'b0;
    tick();
    chk("bsel_restart", 64'(b0), 64'h0);

    // Handshake: C accepted, B held off until the next commit
    cfg_valid = 1'b1;
    cfg_data  = mkword(8'h30, 8'h11, 8'h22, 8'hC3, 8'h81);
    tick();
    cfg_data = mkword(8'h50, 8'h77, 8'h3C, 8'h55, 8'h66);
    tick();
    chk("B_block1", 64'(if0.cfg_ready), 64'h0);
    tick();
    chk("B_block2", 64'(if0.cfg_ready), 64'h0);
    pwm = 1'b1;
    tick();
    chk("C_commit_ready", 64'(if0.cfg_ready), 64'h1);
    tick();
    chk("B_accepted", 64'(if0.cfg_ready), 64'h0);
    cfg_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("C_drive_p", 64'(p0), 64'h011);

    // Edges during DEAD restart the dead count; B commits on the first one
    pwm = 1'b0;
    tick();
    chk("redead1", 64'(a0), 64'h0);
    pwm = 1'b1;
    tick();
    chk("redead2", 64'(a0), 64'h0);
    pwm = 1'b0;
    tick();
    chk("redead3_p", 64'(p0), 64'h0FF);
    chk("redead3_n", 64'(n0), 64'h000);
    tick();
    chk("redead4_p", 64'(p0), 64'h0FF);
    chk("redead4_n", 64'(n0), 64'h000);
    tick();
    chk("N_drive_n", 64'(n0), 64'h03C);
    chk("N_drive_p", 64'(p0), 64'h0FF);

    // Reset in DRIVE_N with a pending word: the word is discarded
    cfg_valid = 1'b1;
    cfg_data  = mkword(8'h70, 8'hEE, 8'hDD, 8'h99, 8'h12);
    tick();
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_p", 64'(p0), 64'h0FF);
    chk("mid_rst_n", 64'(n0), 64'h000);
    chk("mid_rst_ready", 64'(if0.cfg_ready), 64'h1);
    chk("mid_rst_act", 64'(a0), 64'h0);
    rst_n = 1'b1;
    pwm = 1'b1;
    tick();
    tick();
    tick();
    chk("post_rst_p", 64'(p0), 64'h000);

    // en=0 forces idle; en=1 alone does not restart driving
    en = 1'b0;
    tick();
    chk("en_off_act", 64'(a0), 64'h0);
    en = 1'b1;
    tick();
    chk("en_back_idle", 64'(a0), 64'h0);

    // Mixed traffic
    for (int i = 0; i < 48; i++) begin
      if ((i % 7) == 3 || (i % 11) == 0) pwm = ~pwm;
      en        = !(i >= 20 && i <= 22);
      cfg_valid = ((i % 4) == 1);
      cfg_data  = mkword(8'(i * 13), 8'(i * 5 + 1), 8'(i * 3 + 2), 8'(i * 17), 8'(i * 9 + 4));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
